// File: rtl/alu_share_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU sharing block.
// No logic of its own; the FSM state encoding and one-hot helper live here.
package alu_share_arbiter_pkg;

    localparam int DW_DEF = 6;
    localparam int SW_DEF = 4;
    localparam int CNT_W  = 4;

    localparam logic [SW_DEF-1:0] SEL_NOP = 4'b0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request, ALU-side and response bundle between two control units, the arbiter and the ALU.
// slave = arbiter view; master = the surrounding requesters/ALU view.
interface alu_share_arbiter_if
    import alu_share_arbiter_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int SW = SW_DEF
);
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [SW-1:0] req0_sel;
    logic [SW-1:0] req1_sel;
    logic [DW-1:0] req0_a;
    logic [DW-1:0] req1_a;
    logic [DW-1:0] req0_b;
    logic [DW-1:0] req1_b;
    logic [SW-1:0] alu_sel;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [DW-1:0] alu_result;
    logic [1:0]    rsp_valid;
    logic [1:0]    rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;

    modport slave (
        input  req_valid, req0_sel, req1_sel, req0_a, req1_a, req0_b, req1_b,
        input  alu_result, rsp_ready,
        output req_ready, alu_sel, alu_a, alu_b, rsp_valid, rsp_data, rsp_err
    );

    modport master (
        output req_valid, req0_sel, req1_sel, req0_a, req1_a, req0_b, req1_b,
        output alu_result, rsp_ready,
        input  req_ready, alu_sel, alu_a, alu_b, rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/alu_share_arbiter_rr.sv
// Two-way round-robin grant: combinational one-hot grant, last_grant updated on accept.
// Zero latency; grant is simply withheld when no request is present.
module rr_arbiter2
    import alu_share_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant,
    output logic       idx
);

    logic last_grant;

    always_comb begin
        idx = ~last_grant;
        case (req)
            2'b01:   idx = 1'b0;
            2'b10:   idx = 1'b1;
            default: idx = ~last_grant;
        endcase
        grant = req[idx] ? onehot2(idx) : 2'b00;
    end

    // Reset to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= idx;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between two requesters: accept, drive ALU for ALU_LAT cycles, hold response.
// Accept-to-rsp_valid is ALU_LAT+1 (1 for a NOP select); one command in flight, rsp held until rsp_ready.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int SW      = SW_DEF,
    parameter int ALU_LAT = 1
)(
    input  logic          clk,
    input  logic          rst_n,
    alu_share_arbiter_if.slave bus,
    output logic          busy
);

    state_t           state;
    state_t           nxt;
    logic [1:0]       grant;
    logic             gidx;
    logic             accept;
    logic             owner;
    logic [CNT_W-1:0] cnt;
    logic [SW-1:0]    in_sel;
    logic [DW-1:0]    in_a;
    logic [DW-1:0]    in_b;
    logic             in_nop;

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (bus.req_valid),
        .accept (accept),
        .grant  (grant),
        .idx    (gidx)
    );

    assign accept        = (state == IDLE) && (grant != 2'b00);
    assign bus.req_ready = (state == IDLE) ? grant : 2'b00;
    assign busy          = (state != IDLE);

    assign in_sel = gidx ? bus.req1_sel : bus.req0_sel;
    assign in_a   = gidx ? bus.req1_a   : bus.req0_a;
    assign in_b   = gidx ? bus.req1_b   : bus.req0_b;
    assign in_nop = (in_sel == SW'(SEL_NOP));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE: if (accept) nxt = in_nop ? RESP : EXEC;
            EXEC: if (cnt == '0) nxt = RESP;
            RESP: if (bus.rsp_ready[owner]) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // The ALU select/operand registers double as the latched command, so a NOP never reaches the ALU.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner         <= 1'b0;
            cnt           <= '0;
            bus.alu_sel   <= '0;
            bus.alu_a     <= '0;
            bus.alu_b     <= '0;
            bus.rsp_valid <= 2'b00;
            bus.rsp_data  <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner <= gidx;
                        cnt   <= CNT_W'(ALU_LAT - 1);
                        if (in_nop) begin
                            bus.rsp_valid <= onehot2(gidx);
                            bus.rsp_err   <= 1'b1;
                            bus.rsp_data  <= '0;
                        end else begin
                            bus.alu_sel <= in_sel;
                            bus.alu_a   <= in_a;
                            bus.alu_b   <= in_b;
                        end
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        bus.alu_sel   <= '0;
                        bus.alu_a     <= '0;
                        bus.alu_b     <= '0;
                        bus.rsp_data  <= bus.alu_result;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_valid <= onehot2(owner);
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready[owner]) begin
                        bus.rsp_valid <= 2'b00;
                        bus.rsp_err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: cycle table, hand sequences and a randomized run on three latencies.
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1_n, rst3_n, rst4_n;
    logic busy1, busy3, busy4;
    logic [5:0] r4;

    alu_share_arbiter_if #(.DW(6), .SW(4)) i1 ();
    alu_share_arbiter_if #(.DW(6), .SW(4)) i3 ();
    alu_share_arbiter_if #(.DW(6), .SW(4)) i4 ();

    function automatic logic [5:0] alu_fn(input logic [3:0] s, input logic [5:0] a, input logic [5:0] b);
        case (s)
            4'd1:    return a;
            4'd2:    return b;
            default: return a ^ b;
        endcase
    endfunction

    assign i1.alu_result = alu_fn(i1.alu_sel, i1.alu_a, i1.alu_b);
    assign i3.alu_result = alu_fn(i3.alu_sel, i3.alu_a, i3.alu_b);
    assign i4.alu_result = r4;

    alu_share_arbiter #(.DW(6), .SW(4), .ALU_LAT(1)) d1 (.clk(clk), .rst_n(rst1_n), .bus(i1), .busy(busy1));
    alu_share_arbiter #(.DW(6), .SW(4), .ALU_LAT(3)) d3 (.clk(clk), .rst_n(rst3_n), .bus(i3), .busy(busy3));
    alu_share_arbiter #(.DW(6), .SW(4), .ALU_LAT(4)) d4 (.clk(clk), .rst_n(rst4_n), .bus(i4), .busy(busy4));

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0] rv;
        logic [3:0] s0; logic [5:0] a0; logic [5:0] ob0;
        logic [3:0] s1; logic [5:0] a1; logic [5:0] ob1;
        logic [1:0] rdy;
        logic [1:0] e_rdy; logic [3:0] e_sel; logic [5:0] e_a;
        logic [1:0] e_vld; logic [5:0] e_dat; logic e_err; logic e_busy; logic dchk;
    } vec_t;

    vec_t tbl [20];

    task automatic drive1(input vec_t v);
        i1.req_valid = v.rv;
        i1.req0_sel = v.s0; i1.req0_a = v.a0; i1.req0_b = v.ob0;
        i1.req1_sel = v.s1; i1.req1_a = v.a1; i1.req1_b = v.ob1;
        i1.rsp_ready = v.rdy;
    endtask

    localparam int L1 = 1;

    logic       m_busy, m_own, m_last, g;
    logic [3:0] m_sel, e_sel;
    logic [5:0] m_dat;
    logic       m_err;
    int         m_acc, m_rsp;

    initial begin
        rst1_n = 1'b0; rst3_n = 1'b0; rst4_n = 1'b0; r4 = 6'h11;
        i1.req_valid = 0; i1.rsp_ready = 0; i1.req0_sel = 0; i1.req1_sel = 0;
        i1.req0_a = 0; i1.req0_b = 0; i1.req1_a = 0; i1.req1_b = 0;
        i3.req_valid = 0; i3.rsp_ready = 0; i3.req0_sel = 0; i3.req1_sel = 0;
        i3.req0_a = 0; i3.req0_b = 0; i3.req1_a = 0; i3.req1_b = 0;
        i4.req_valid = 0; i4.rsp_ready = 0; i4.req0_sel = 0; i4.req1_sel = 0;
        i4.req0_a = 0; i4.req0_b = 0; i4.req1_a = 0; i4.req1_b = 0;

        // rv, s0,a0,b0, s1,a1,b1, rdy | req_ready, alu_sel, alu_a, rsp_valid, rsp_data, rsp_err, busy, check_data
        tbl[0]  = '{2'b00, 4'd0, 6'd0, 6'd0,  4'd0, 6'd0, 6'd0, 2'b00, 2'b00, 4'd0, 6'd0,  2'b00, 6'd0,  1'b0, 1'b0, 1'b1};
        tbl[1]  = '{2'b01, 4'd1, 6'd21,6'd5,  4'd0, 6'd0, 6'd0, 2'b00, 2'b01, 4'd0, 6'd0,  2'b00, 6'd0,  1'b0, 1'b0, 1'b1};
        tbl[2]  = '{2'b00, 4'd1, 6'd21,6'd5,  4'd0, 6'd0, 6'd0, 2'b00, 2'b00, 4'd1, 6'd21, 2'b00, 6'd0,  1'b0, 1'b1, 1'b0};
        tbl[3]  = '{2'b00, 4'd0, 6'd0, 6'd0,  4'd0, 6'd0, 6'd0, 2'b00, 2'b00, 4'd0, 6'd0,  2'b01, 6'd21, 1'b0, 1'b1, 1'b1};
        tbl[4]  = '{2'b00, 4'd0, 6'd0, 6'd0,  4'd0, 6'd0, 6'd0, 2'b10, 2'b00, 4'd0, 6'd0,  2'b01, 6'd21, 1'b0, 1'b1, 1'b1};
        tbl[5]  = '{2'b00, 4'd0, 6'd0, 6'd0,  4'd0, 6'd0, 6'd0, 2'b01, 2'b00, 4'd0, 6'd0,  2'b01, 6'd21, 1'b0, 1'b1, 1'b1};
        tbl[6]  = '{2'b10, 4'd0, 6'd0, 6'd0,  4'd0, 6'd9, 6'd9, 2'b00, 2'b10, 4'd0, 6'd0,  2'b00, 6'd0,  1'b0, 1'b0, 1'b0};
        tbl[7]  = '{2'b00, 4'd0, 6'd0, 6'd0,  4'd0, 6'd0, 6'd0, 2'b10, 2'b00, 4'd0, 6'd0,  2'b10, 6'd0,  1'b1, 1'b1, 1'b1};
        tbl[8]  = '{2'b11, 4'd2, 6'd3, 6'd7,  4'd2, 6'd4, 6'd9, 2'b00, 2'b01, 4'd0, 6'd0,  2'b00, 6'd0,  1'b0, 1'b0, 1'b0};
        tbl[9]  = '{2'b11, 4'd2, 6'd3, 6'd7,  4'd2, 6'd4, 6'd9, 2'b00, 2'b00, 4'd2, 6'd3,  2'b00, 6'd0,  1'b0, 1'b1, 1'b0};
        tbl[10] = '{2'b11, 4'd2, 6'd3, 6'd7,  4'd2, 6'd4, 6'd9, 2'b11, 2'b00, 4'd0, 6'd0,  2'b01, 6'd7,  1'b0, 1'b1, 1'b1};
        tbl[11] = '{2'b11, 4'd2, 6'd3, 6'd7,  4'd2, 6'd4, 6'd9, 2'b00, 2'b10, 4'd0, 6'd0,  2'b00, 6'd0,  1'b0, 1'b0, 1'b0};
        tbl[12] = '{2'b11, 4'd2, 6'd3, 6'd7,  4'd2, 6'd4, 6'd9, 2'b00, 2'b00, 4'd2, 6'd4,  2'b00, 6'd0,  1'b0, 1'b1, 1'b0};
        tbl[13] = '{2'b11, 4'd2, 6'd3, 6'd7,  4'd2, 6'd4, 6'd9, 2'b00, 2'b00, 4'd0, 6'd0,  2'b10, 6'd9,  1'b0, 1'b1, 1'b1};
        tbl[14] = '{2'b11, 4'd2, 6'd3, 6'd7,  4'd2, 6'd4, 6'd9, 2'b01, 2'b00, 4'd0, 6'd0,  2'b10, 6'd9,  1'b0, 1'b1, 1'b1};
        tbl[15] = '{2'b11, 4'd2, 6'd3, 6'd7,  4'd2, 6'd4, 6'd9, 2'b10, 2'b00, 4'd0, 6'd0,  2'b10, 6'd9,  1'b0, 1'b1, 1'b1};
        tbl[16] = '{2'b11, 4'd2, 6'd3, 6'd7,  4'd2, 6'd4, 6'd9, 2'b00, 2'b01, 4'd0, 6'd0,  2'b00, 6'd0,  1'b0, 1'b0, 1'b0};
        tbl[17] = '{2'b00, 4'd2, 6'd3, 6'd7,  4'd2, 6'd4, 6'd9, 2'b00, 2'b00, 4'd2, 6'd3,  2'b00, 6'd0,  1'b0, 1'b1, 1'b0};
        tbl[18] = '{2'b00, 4'd0, 6'd0, 6'd0,  4'd0, 6'd0, 6'd0, 2'b11, 2'b00, 4'd0, 6'd0,  2'b01, 6'd7,  1'b0, 1'b1, 1'b1};
        tbl[19] = '{2'b00, 4'd0, 6'd0, 6'd0,  4'd0, 6'd0, 6'd0, 2'b00, 2'b00, 4'd0, 6'd0,  2'b00, 6'd0,  1'b0, 1'b0, 1'b0};

        #12;
        rst1_n = 1'b1; rst3_n = 1'b1; rst4_n = 1'b1;
        tick();

        for (int i = 0; i < 20; i++) begin
            drive1(tbl[i]);
            @(negedge clk);
            chk($sformatf("tbl%0d_req_ready", i), i1.req_ready, tbl[i].e_rdy);
            chk($sformatf("tbl%0d_alu_sel", i),   i1.alu_sel,   tbl[i].e_sel);
            chk($sformatf("tbl%0d_alu_a", i),     i1.alu_a,     tbl[i].e_a);
            chk($sformatf("tbl%0d_rsp_valid", i), i1.rsp_valid, tbl[i].e_vld);
            chk($sformatf("tbl%0d_rsp_err", i),   i1.rsp_err,   tbl[i].e_err);
            chk($sformatf("tbl%0d_busy", i),      busy1,        tbl[i].e_busy);
            if (tbl[i].dchk) chk($sformatf("tbl%0d_rsp_data", i), i1.rsp_data, tbl[i].e_dat);
            tick();
        end

        // Response backpressure: requester 1 waits while requester 0 holds its response.
        i1.req_valid = 2'b01; i1.req0_sel = 4'd1; i1.req0_a = 6'd13; i1.req0_b = 6'd1; i1.rsp_ready = 2'b00;
        @(negedge clk); chk("bp_accept0", i1.req_ready, 2'b01);
        tick();
        i1.req_valid = 2'b10; i1.req1_sel = 4'd3; i1.req1_a = 6'd5; i1.req1_b = 6'd6;
        @(negedge clk); chk("bp_exec_rdy", i1.req_ready, 2'b00);
        tick();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_rsp_valid", k), i1.rsp_valid, 2'b01);
            chk($sformatf("bp%0d_rsp_data", k),  i1.rsp_data,  6'd13);
            chk($sformatf("bp%0d_req_ready", k), i1.req_ready, 2'b00);
            tick();
        end
        i1.rsp_ready = 2'b01;
        @(negedge clk); chk("bp_release_vld", i1.rsp_valid, 2'b01);
        tick();
        i1.rsp_ready = 2'b00;
        @(negedge clk);
        chk("bp_idle_busy", busy1, 1'b0);
        chk("bp_idle_rdy1", i1.req_ready, 2'b10);
        tick();
        i1.req_valid = 2'b00;
        @(negedge clk); chk("bp_req1_sel", i1.alu_sel, 4'd3);
        tick();
        @(negedge clk);
        chk("bp_req1_vld", i1.rsp_valid, 2'b10);
        chk("bp_req1_dat", i1.rsp_data, 6'd3);
        i1.rsp_ready = 2'b10;
        tick();
        i1.rsp_ready = 2'b00;

        // Randomized run; requester 1 held the most recent grant.
        m_busy = 1'b0; m_last = 1'b1; m_own = 1'b0; m_sel = 0; m_dat = 0; m_err = 0; m_acc = 0; m_rsp = 0;
        for (int c = 0; c < 400; c++) begin
            i1.req_valid = 2'($urandom_range(0, 3));
            i1.req0_sel  = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            i1.req1_sel  = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            i1.req0_a = 6'($urandom); i1.req0_b = 6'($urandom);
            i1.req1_a = 6'($urandom); i1.req1_b = 6'($urandom);
            i1.rsp_ready = 2'($urandom_range(0, 3));
            @(negedge clk);
            if (!m_busy) begin
                g = (i1.req_valid == 2'b01) ? 1'b0 : (i1.req_valid == 2'b10) ? 1'b1 : ~m_last;
                chk("rnd_req_ready", i1.req_ready, (i1.req_valid == 2'b00) ? 2'b00 : (g ? 2'b10 : 2'b01));
                chk("rnd_idle_vld", i1.rsp_valid, 2'b00);
                chk("rnd_idle_sel", i1.alu_sel, 4'd0);
                if (i1.req_valid != 2'b00) begin
                    m_busy = 1'b1; m_own = g; m_last = g; m_acc = c;
                    m_sel  = g ? i1.req1_sel : i1.req0_sel;
                    if (m_sel == 4'd0) begin
                        m_rsp = c + 1; m_dat = 6'd0; m_err = 1'b1;
                    end else begin
                        m_rsp = c + 1 + L1; m_err = 1'b0;
                        m_dat = g ? alu_fn(m_sel, i1.req1_a, i1.req1_b) : alu_fn(m_sel, i1.req0_a, i1.req0_b);
                    end
                end
            end else begin
                chk("rnd_busy_rdy", i1.req_ready, 2'b00);
                e_sel = (m_sel != 4'd0 && c > m_acc && c <= m_acc + L1) ? m_sel : 4'd0;
                chk("rnd_alu_sel", i1.alu_sel, e_sel);
                if (c >= m_rsp) begin
                    chk("rnd_rsp_valid", i1.rsp_valid, m_own ? 2'b10 : 2'b01);
                    chk("rnd_rsp_data", i1.rsp_data, m_dat);
                    chk("rnd_rsp_err", i1.rsp_err, m_err);
                    if (i1.rsp_ready[m_own]) m_busy = 1'b0;
                end else begin
                    chk("rnd_rsp_early", i1.rsp_valid, 2'b00);
                end
            end
            tick();
        end
        i1.req_valid = 2'b00; i1.rsp_ready = 2'b11;

        // Reset in the middle of a 3-cycle execution.
        i3.req_valid = 2'b01; i3.req0_sel = 4'd3; i3.req0_a = 6'd1; i3.req0_b = 6'd2;
        @(negedge clk); chk("rst_accept", i3.req_ready, 2'b01);
        tick();
        i3.req_valid = 2'b00;
        @(negedge clk); chk("rst_exec_sel", i3.alu_sel, 4'd3);
        tick();
        #2 rst3_n = 1'b0;
        #1;
        chk("rst_async_sel", i3.alu_sel, 4'd0);
        chk("rst_async_vld", i3.rsp_valid, 2'b00);
        chk("rst_async_busy", busy3, 1'b0);
        rst3_n = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("rst_after%0d_vld", k), i3.rsp_valid, 2'b00);
            chk($sformatf("rst_after%0d_busy", k), busy3, 1'b0);
            tick();
        end
        i3.req_valid = 2'b11;
        @(negedge clk); chk("rst_first_grant", i3.req_ready, 2'b01);
        tick();
        i3.req_valid = 2'b00; i3.rsp_ready = 2'b11;

        // Four-cycle latency: operands stable, result sampled in the final cycle.
        r4 = 6'h11;
        i4.req_valid = 2'b10; i4.req1_sel = 4'd5; i4.req1_a = 6'd33; i4.req1_b = 6'd44;
        @(negedge clk); chk("lat4_accept", i4.req_ready, 2'b10);
        tick();
        i4.req_valid = 2'b00;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) r4 = 6'h2A;
            @(negedge clk);
            chk($sformatf("lat4_c%0d_sel", k), i4.alu_sel, 4'd5);
            chk($sformatf("lat4_c%0d_a", k),   i4.alu_a,   6'd33);
            chk($sformatf("lat4_c%0d_b", k),   i4.alu_b,   6'd44);
            chk($sformatf("lat4_c%0d_vld", k), i4.rsp_valid, 2'b00);
            tick();
        end
        r4 = 6'h05;
        @(negedge clk);
        chk("lat4_rsp_vld", i4.rsp_valid, 2'b10);
        chk("lat4_rsp_dat", i4.rsp_data, 6'h2A);
        chk("lat4_rsp_sel", i4.alu_sel, 4'd0);
        i4.rsp_ready = 2'b10;
        tick();
        i4.rsp_ready = 2'b00;
        @(negedge clk); chk("lat4_done_busy", busy4, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one ALU datapath (6-bit operands A/B, 4-bit function select) between two requesters.
- Round-robin arbitration, command capture, select/operand driving for a fixed ALU latency, result capture, and per-requester response handshake.
- Sits between the requesting control units and the ALU operand-select/function logic. Owns alu_sel: the ALU sees a non-zero select only while a granted command is in flight.

Parameters:
- DW, 6, operand/result width.
- SW, 4, ALU function-select width.
- ALU_LAT, 1, cycles from operands/select applied to result valid. Legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  per-requester command valid; bit i is requester i.
- req_ready  out  2  per-requester command accept.
- req0_sel, req1_sel  in  SW  requested ALU function. 4'b0000 is illegal (no-op).
- req0_a, req1_a  in  DW  operand A.
- req0_b, req1_b  in  DW  operand B.
- alu_sel  out  SW  function select to the ALU.
- alu_a, alu_b  out  DW  operands to the ALU.
- alu_result  in  DW  ALU output.
- rsp_valid  out  2  per-requester response valid.
- rsp_ready  in  2  per-requester response accept.
- rsp_data  out  DW  result, shared by both requesters and qualified by rsp_valid.
- rsp_err  out  1  illegal-select flag, qualified by rsp_valid.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values:
  - state=IDLE; all outputs 0 (alu_sel=0, alu_a=0, alu_b=0, rsp_valid=0, rsp_data=0, rsp_err=0, req_ready=0, busy=0).
  - last_grant=1, so requester 0 wins the first contention.
  - Reset asserted mid-operation aborts the transaction: no response is issued and the ALU select returns to 0 immediately.
- IDLE:
  - Grant g is derived combinationally. If only one req_valid bit is set, g is that index. If both are set, g = ~last_grant.
  - req_ready[g] = 1 only in IDLE and only when req_valid[g] = 1. The other req_ready bit is 0.
  - On the handshake, latch sel/a/b of requester g, set last_grant=g, then:
    - sel==0: go to RESP with rsp_err=1 and rsp_data=0 (ALU not used).
    - otherwise: go to EXEC.
- EXEC:
  - alu_sel, alu_a, alu_b are registered and driven from the latched command for exactly ALU_LAT cycles. A down-counter is loaded with ALU_LAT-1.
  - When the counter reaches 0, capture alu_result into rsp_data and go to RESP.
  - The ALU inputs are held stable for the whole EXEC period.
- RESP:
  - alu_sel=0, alu_a=0, alu_b=0.
  - rsp_valid[g]=1; the other rsp_valid bit is 0. rsp_data and rsp_err are held stable.
  - On rsp_ready[g]: clear rsp_valid and rsp_err, go to IDLE.
  - rsp_ready on the non-granted bit is ignored.
- Latency: request accept to rsp_valid = ALU_LAT+1 cycles; 1 cycle for an illegal select.
- Throughput and contention:
  - One transaction in flight; no new accept until the cycle after the response handshake (IDLE is visited for at least 1 cycle).
  - req_valid may drop without a handshake; no state changes.
  - Under continuous contention, grants alternate 0,1,0,1.
- Width rules:
  - Data passes through unchanged. No arithmetic is performed here; width checks are the ALU's responsibility.
  - Counter width is 4 bits.
- X safety: latched command registers update only on a handshake, and rsp_data only at the EXEC end.

Decomposition:
- Shared package holds:
  - state enum IDLE=2'd0, EXEC=2'd1, RESP=2'd2;
  - SEL_NOP = 4'b0000;
  - DW/SW defaults.
- One natural sub-module, rr_arbiter2: a 2-way round-robin grant with a last_grant register, an update-on-accept input, and a one-hot grant output.
- FSM, counter and datapath registers stay in the top.

Test Plan:
- Reset: after reset release, all outputs 0. Assert rst_n low during EXEC with ALU_LAT=3 → alu_sel=0 and rsp_valid=0 asynchronously; after release, state IDLE.
- Single requester (req 0): sel=4'b0001, a=6'd21, b=6'd5, ALU_LAT=1, ALU model returns A.
  - req_ready[0] is high in the same cycle as the request.
  - alu_sel=1 for exactly 1 cycle.
  - rsp_valid[0]=1 two cycles after accept, with rsp_data=21 and rsp_err=0.
- Contention: both req_valid high continuously, sel=4'b0010 for both, b0=7, b1=9 → grants alternate 0,1,0,1 and rsp_data alternates 7,9,7,9.
- Illegal select: req 1 with sel=0 → ALU is never driven (alu_sel stays 0); the next cycle rsp_valid[1]=1, rsp_err=1, rsp_data=0.
- Response backpressure: hold rsp_ready[0]=0 for 5 cycles while req 1 is valid → rsp_valid[0] and rsp_data are stable and req_ready[1] stays 0. Then raise rsp_ready[0] → IDLE for 1 cycle, after which req 1 is accepted.
- ALU_LAT=4: alu_a, alu_b and alu_sel are held constant for 4 cycles; the ALU model changes alu_result only in the final cycle → rsp_data equals that final value.
